// File: rtl/jtag_dr_seq_pkg.sv
// Shared types for the JTAG data-register sequencer: FSM state encoding,
// command error causes and the command legality check.
package jtag_dr_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEL   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_RSP   = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_LEN_ZERO = 3'd1,
        ERR_LEN_OVER = 3'd2,
        ERR_CHAIN    = 3'd3,
        ERR_ABORT    = 3'd4
    } err_cause_e;

    // Classify an offered command; anything but ERR_NONE is answered
    // immediately with an error response and never touches the scan chains.
    function automatic err_cause_e check_cmd(input int len, input int chain,
                                             input int max_len, input int num_chains);
        err_cause_e cause;
        if (len == 0)                cause = ERR_LEN_ZERO;
        else if (len > max_len)      cause = ERR_LEN_OVER;
        else if (chain >= num_chains) cause = ERR_CHAIN;
        else                         cause = ERR_NONE;
        return cause;
    endfunction

endpackage

// File: rtl/jtag_dr_seq_sbuf.sv
// Serial shift/capture buffer: presents write data LSB first, records the
// returned serial bits at the position of the current bit counter.
module jtag_dr_seq_sbuf #(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [LEN_W-1:0]   load_len,
    input  logic [MAX_LEN-1:0] load_data,
    input  logic               shift_en,
    input  logic               cap_en,
    input  logic               cap_bit,
    output logic               scan_bit,
    output logic               last,
    output logic [MAX_LEN-1:0] rdata
);

    logic [MAX_LEN-1:0] wbuf_q, wbuf_d;
    logic [MAX_LEN-1:0] rbuf_q, rbuf_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;

    assign scan_bit = wbuf_q[0];
    assign last     = (cnt_q == len_q - 1'b1);
    assign rdata    = rbuf_q;

    // Load clears the capture buffer so bits beyond the length read as zero;
    // the counter saturates at the last bit so it can never wrap.
    always_comb begin
        wbuf_d = wbuf_q;
        rbuf_d = rbuf_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        if (load) begin
            wbuf_d = load_data;
            rbuf_d = '0;
            len_d  = load_len;
            cnt_d  = '0;
        end else if (shift_en) begin
            wbuf_d = {1'b0, wbuf_q[MAX_LEN-1:1]};
            if (cap_en) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (cnt_q == LEN_W'(i)) rbuf_d[i] = cap_bit;
                end
            end
            if (!last) cnt_d = cnt_q + 1'b1;
        end
    end

    // Buffer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wbuf_q <= '0;
            rbuf_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else begin
            wbuf_q <= wbuf_d;
            rbuf_q <= rbuf_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/jtag_dr_seq.sv
// JTAG data-register sequencer: takes one shift command at a time, selects
// the target register for a capture cycle, shifts len bits through it and
// returns the captured bits as a held response.
module jtag_dr_seq
    import jtag_dr_seq_pkg::*;
#(
    parameter int NUM_CHAINS = 4,
    parameter int MAX_LEN    = 64,
    parameter int LEN_W      = 7,
    localparam int CH_W      = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [CH_W-1:0]       cmd_chain,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [MAX_LEN-1:0]    cmd_wdata,
    input  logic                  abort,
    output logic [NUM_CHAINS-1:0] sel,
    output logic                  shiftDR,
    output logic                  scanin,
    input  logic [NUM_CHAINS-1:0] scanout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [MAX_LEN-1:0]    rsp_rdata,
    output logic                  rsp_err
);

    state_e          state_q, state_d;
    err_cause_e      err_q, err_d;
    err_cause_e      cause;
    logic [CH_W-1:0] chain_q, chain_d;
    logic            load, shift_en, cap_en, scan_bit, last, sel_act;

    jtag_dr_seq_sbuf #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_sbuf (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_len  (cmd_len),
        .load_data (cmd_wdata),
        .shift_en  (shift_en),
        .cap_en    (cap_en),
        .cap_bit   (scanout[chain_q]),
        .scan_bit  (scan_bit),
        .last      (last),
        .rdata     (rsp_rdata)
    );

    // Ready is withheld while reset is asserted so nothing is accepted then.
    assign cmd_ready = (state_q == ST_IDLE) && !reset;
    assign cause     = check_cmd(32'(cmd_len), 32'(cmd_chain), MAX_LEN, NUM_CHAINS);
    assign sel_act   = (state_q == ST_SEL) || (state_q == ST_SHIFT);
    assign shiftDR   = (state_q == ST_SHIFT);
    assign scanin    = (state_q == ST_SHIFT) && scan_bit;
    assign rsp_valid = (state_q == ST_RSP);
    assign rsp_err   = (state_q == ST_RSP) && (err_q != ERR_NONE);

    // One-hot register select, driven only while a valid command owns the chain.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_CHAINS; i++) begin
            sel[i] = sel_act && (chain_q == CH_W'(i));
        end
    end

    // Next-state logic; an abort stops capture on its own cycle so only
    // bits completed before it are reported.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        chain_d  = chain_q;
        load     = 1'b0;
        shift_en = 1'b0;
        cap_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    load    = 1'b1;
                    chain_d = cmd_chain;
                    err_d   = cause;
                    state_d = (cause == ERR_NONE) ? ST_SEL : ST_RSP;
                end
            end
            ST_SEL: begin
                if (abort) begin
                    err_d   = ERR_ABORT;
                    state_d = ST_RSP;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                cap_en   = !abort;
                if (abort) begin
                    err_d   = ERR_ABORT;
                    state_d = ST_RSP;
                end else if (last) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            err_q   <= ERR_NONE;
            chain_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            chain_q <= chain_d;
        end
    end

endmodule

// File: tb/tb_jtag_dr_seq.sv
// Bench for jtag_dr_seq: scan registers modelled around the DUT, a
// transaction-level schedule model compared every cycle, plus literal checks.
module tb_jtag_dr_seq;

    localparam int NC = 4;
    localparam int ML = 64;
    localparam int LW = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_chain;
    logic [LW-1:0] cmd_len;
    logic [ML-1:0] cmd_wdata;
    logic          abort;
    logic [NC-1:0] sel;
    logic          shiftDR, scanin;
    logic [NC-1:0] scanout;
    logic          rsp_valid, rsp_ready;
    logic [ML-1:0] rsp_rdata;
    logic          rsp_err;

    logic       c3_cmd_valid, c3_cmd_ready;
    logic [1:0] c3_cmd_chain;
    logic [3:0] c3_cmd_len;
    logic [7:0] c3_cmd_wdata;
    logic [2:0] c3_sel;
    logic       c3_shiftDR, c3_scanin, c3_rsp_valid, c3_rsp_err;
    logic [7:0] c3_rsp_rdata;

    int checks   = 0;
    int failures = 0;

    jtag_dr_seq #(.NUM_CHAINS(NC), .MAX_LEN(ML), .LEN_W(LW)) u_dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_chain(cmd_chain), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata), .abort(abort),
        .sel(sel), .shiftDR(shiftDR), .scanin(scanin), .scanout(scanout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    // Three-chain instance so an out-of-range chain index is representable.
    jtag_dr_seq #(.NUM_CHAINS(3), .MAX_LEN(8), .LEN_W(4)) u_dut3 (
        .clk(clk), .reset(reset), .cmd_valid(c3_cmd_valid), .cmd_ready(c3_cmd_ready),
        .cmd_chain(c3_cmd_chain), .cmd_len(c3_cmd_len), .cmd_wdata(c3_cmd_wdata), .abort(1'b0),
        .sel(c3_sel), .shiftDR(c3_shiftDR), .scanin(c3_scanin), .scanout(3'b000),
        .rsp_valid(c3_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(c3_rsp_rdata), .rsp_err(c3_rsp_err)
    );

    always #5 clk = ~clk;

    // Scan registers: capture D when selected without shift, otherwise shift
    // scanin in at the top and present bit 0 on scanout.
    int            chain_len [NC] = '{12, 64, 8, 20};
    logic [ML-1:0] d_val [NC];
    logic [ML-1:0] q_reg [NC];

    function automatic logic [ML-1:0] lmask(input int n);
        if (n >= ML) return '1;
        return (64'd1 << n) - 64'd1;
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < NC; c++) begin
            if (sel[c]) begin
                if (!shiftDR) q_reg[c] <= d_val[c] & lmask(chain_len[c]);
                else          q_reg[c] <= (q_reg[c] >> 1) | ({63'd0, scanin} << (chain_len[c] - 1));
            end
        end
    end

    always_comb begin
        scanout = '0;
        for (int c = 0; c < NC; c++) scanout[c] = q_reg[c][0];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: t counts cycles since acceptance (1 = select cycle,
    // 2..len+1 = shift cycles); the response holds until rsp_ready.
    bit             m_active = 0, m_rsp = 0, m_rerr = 0;
    int             m_t = 0, m_len = 0, m_chain = 0;
    logic [ML-1:0]  m_wdata, m_rdata;
    logic [127:0]   m_stream;
    int             sel_cyc = 0, sdr_cyc = 0;

    task automatic model_step();
        logic [NC-1:0] e_sel;
        logic [ML-1:0] tmp;
        logic          e_sdr, e_sin, e_rdy, e_rv;
        int            l;
        e_sel = '0; e_sdr = 0; e_sin = 0; e_rv = 0;
        e_rdy = !reset && !m_active;
        if (m_active) begin
            if (m_rsp) e_rv = 1;
            else begin
                e_sel = NC'(1) << m_chain;
                if (m_t >= 2) begin
                    e_sdr = 1;
                    tmp   = m_wdata >> (m_t - 2);
                    e_sin = tmp[0];
                end
            end
        end
        if (sel != '0) sel_cyc++;
        if (shiftDR) sdr_cyc++;
        chk("cyc_sel", sel, e_sel);
        chk("cyc_shiftDR", shiftDR, e_sdr);
        chk("cyc_scanin", scanin, e_sin);
        chk("cyc_cmd_ready", cmd_ready, e_rdy);
        chk("cyc_rsp_valid", rsp_valid, e_rv);
        if (e_rv) begin
            chk("cyc_rsp_err", rsp_err, m_rerr);
            chk("cyc_rsp_rdata", rsp_rdata, m_rdata);
        end
        if (reset) m_active = 0;
        else if (!m_active) begin
            if (cmd_valid) begin
                m_active = 1;
                m_chain  = int'(cmd_chain);
                m_len    = int'(cmd_len);
                m_wdata  = cmd_wdata;
                if (m_len == 0 || m_len > ML) begin
                    m_rsp = 1; m_rerr = 1; m_rdata = '0;
                end else begin
                    l        = chain_len[m_chain];
                    m_rsp    = 0;
                    m_t      = 1;
                    m_stream = ({64'd0, cmd_wdata & lmask(m_len)} << l) |
                               {64'd0, d_val[m_chain] & lmask(l)};
                end
            end
        end else if (!m_rsp) begin
            if (abort) begin
                m_rsp = 1; m_rerr = 1;
                m_rdata = m_stream[63:0] & lmask((m_t >= 2) ? m_t - 2 : 0);
            end else if (m_t == m_len + 1) begin
                m_rsp = 1; m_rerr = 0;
                m_rdata = m_stream[63:0] & lmask(m_len);
            end else m_t++;
        end else if (rsp_ready) begin
            m_active = 0;
        end
    endtask

    task automatic send(input int ch, input int len, input logic [63:0] wd);
        int n = 0;
        cmd_chain = 2'(ch); cmd_len = LW'(len); cmd_wdata = wd; cmd_valid = 1;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("cmd_accept", cmd_ready, 1);
        @(posedge clk); #1 cmd_valid = 0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
        chk("rsp_arrives", rsp_valid, 1);
    endtask

    task automatic finish_rsp();
        @(posedge clk); #1 rsp_ready = 1;
        @(posedge clk); #1 rsp_ready = 0;
    endtask

    task automatic c3_err(input int ch, input int len);
        c3_cmd_chain = 2'(ch); c3_cmd_len = 4'(len); c3_cmd_valid = 1;
        @(negedge clk); chk("c3_ready", c3_cmd_ready, 1);
        @(posedge clk); #1 c3_cmd_valid = 0;
        @(negedge clk);
        chk("c3_rsp_valid", c3_rsp_valid, 1);
        chk("c3_rsp_err", c3_rsp_err, 1);
        chk("c3_rdata", c3_rsp_rdata, 0);
        chk("c3_sel", c3_sel, 0);
        chk("c3_shiftDR", c3_shiftDR, 0);
        @(posedge clk); #1;
    endtask

    task automatic run_tests();
        int lat, s0, d0;
        // reset state
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_sel", sel, 0);
        chk("rst_shiftDR", shiftDR, 0);
        chk("rst_scanin", scanin, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rdata", rsp_rdata, 0);
        @(posedge clk); #1 reset = 0;
        @(negedge clk); chk("post_rst_ready", cmd_ready, 1);
        @(posedge clk); #1 abort = 1;
        repeat (2) @(posedge clk);
        #1 abort = 0;

        // chain 2, len 8
        s0 = sel_cyc; d0 = sdr_cyc;
        send(2, 8, 64'hA5);
        wait_rsp(lat);
        chk("c2_latency", lat, 10);
        chk("c2_rdata", rsp_rdata, 64'h3C);
        chk("c2_err", rsp_err, 0);
        chk("c2_sel_cycles", sel_cyc - s0, 9);
        chk("c2_sdr_cycles", sdr_cyc - d0, 8);
        chk("c2_reg_q", q_reg[2], 64'hA5);
        finish_rsp();

        // full-length shift
        d0 = sdr_cyc;
        send(1, 64, 64'hFFFF_0000_1234_5678);
        wait_rsp(lat);
        chk("c1_latency", lat, 66);
        chk("c1_sdr_cycles", sdr_cyc - d0, 64);
        chk("c1_rdata", rsp_rdata, 64'hDEAD_BEEF_0123_4567);
        chk("c1_reg_q", q_reg[1], 64'hFFFF_0000_1234_5678);
        finish_rsp();

        // shift longer than the register: write data wraps into rdata
        send(0, 20, 64'h5_1234);
        wait_rsp(lat);
        chk("c0_rdata", rsp_rdata, 64'h3_4ABC);
        finish_rsp();

        // error commands
        s0 = sel_cyc;
        send(0, 0, 64'hFF);
        wait_rsp(lat);
        chk("len0_latency", lat, 1);
        chk("len0_err", rsp_err, 1);
        chk("len0_rdata", rsp_rdata, 0);
        finish_rsp();
        send(3, 65, 64'hFF);
        wait_rsp(lat);
        chk("len65_latency", lat, 1);
        chk("len65_err", rsp_err, 1);
        chk("len65_rdata", rsp_rdata, 0);
        finish_rsp();
        chk("err_no_sel", sel_cyc - s0, 0);
        c3_err(3, 4);
        c3_err(0, 9);

        // abort in shift cycle 5
        send(3, 16, 64'hFFFF);
        repeat (6) @(posedge clk);
        #1 abort = 1;
        @(posedge clk); #1 abort = 0;
        @(negedge clk);
        chk("abort_shiftDR", shiftDR, 0);
        chk("abort_rsp_valid", rsp_valid, 1);
        chk("abort_err", rsp_err, 1);
        chk("abort_rdata", rsp_rdata, 64'h05);
        finish_rsp();

        // abort in the select cycle
        send(2, 8, 64'h11);
        abort = 1;
        @(posedge clk); #1 abort = 0;
        @(negedge clk);
        chk("abort_sel_err", rsp_err, 1);
        chk("abort_sel_rdata", rsp_rdata, 0);
        finish_rsp();

        // response held through 10 cycles of back-pressure; abort ignored
        send(2, 8, 64'h0F);
        wait_rsp(lat);
        @(posedge clk); #1 abort = 1;
        repeat (10) @(posedge clk);
        #1 abort = 0;
        @(negedge clk);
        chk("hold_rdata", rsp_rdata, 64'h3C);
        chk("hold_valid", rsp_valid, 1);
        chk("hold_cmd_ready", cmd_ready, 0);
        finish_rsp();

        // reset in the middle of a shift
        send(1, 32, 64'hCAFE);
        repeat (5) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("midrst_sel", sel, 0);
        chk("midrst_shiftDR", shiftDR, 0);
        chk("midrst_scanin", scanin, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_rdata", rsp_rdata, 0);
        chk("midrst_ready", cmd_ready, 1);
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; cmd_valid = 0; cmd_chain = '0; cmd_len = '0; cmd_wdata = '0;
        abort = 0; rsp_ready = 0;
        c3_cmd_valid = 0; c3_cmd_chain = '0; c3_cmd_len = '0; c3_cmd_wdata = '0;
        d_val[0] = 64'hABC;
        d_val[1] = 64'hDEAD_BEEF_0123_4567;
        d_val[2] = 64'h3C;
        d_val[3] = 64'h12345;
        @(posedge clk); #1;
        fork
            forever begin @(negedge clk); model_step(); end
            run_tests();
            begin
                #200000;
                chk("watchdog", 0, 1);
            end
        join_any
        disable fork;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
